// File: rtl/common_defs.sv
// Project-wide word width and default sphere-trace thresholds.
package common_defs;

    localparam int unsigned WORD_WIDTH       = 32;
    localparam logic [31:0] EPSILON_DEFAULT  = 32'h0000_4000;  // ~0.001 in Q8.24
    localparam logic [31:0] MAX_DIST_DEFAULT = 32'h1000_0000;  // 16.0 in Q8.24

endpackage

// File: rtl/vector_pkg.sv
// Q8.24 fixed-point scalar/vector types and helpers shared by the ray-march blocks.
package vector_pkg;

    import common_defs::*;

    localparam int unsigned N         = WORD_WIDTH;
    localparam int unsigned FRAC_BITS = 24;

    typedef logic signed [N-1:0] fp_t;

    typedef struct packed {
        fp_t x;
        fp_t y;
        fp_t z;
    } vec3;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StUpdate,
        StDone
    } march_state_t;

    function automatic fp_t fp_sub(fp_t a, fp_t b);
        return a - b;
    endfunction

    // Full-width product, rescaled back to Q8.24 and truncated to N bits.
    function automatic fp_t fp_mul(fp_t a, fp_t b);
        logic signed [2*N-1:0] prod;
        prod = (2*N)'(a) * (2*N)'(b);
        return fp_t'(prod >>> FRAC_BITS);
    endfunction

    function automatic vec3 vec3_sub(vec3 a, vec3 b);
        vec3 r;
        r.x = fp_sub(a.x, b.x);
        r.y = fp_sub(a.y, b.y);
        r.z = fp_sub(a.z, b.z);
        return r;
    endfunction

    function automatic vec3 vec3_add(vec3 a, vec3 b);
        vec3 r;
        r.x = a.x + b.x;
        r.y = a.y + b.y;
        r.z = a.z + b.z;
        return r;
    endfunction

    function automatic vec3 vec3_scale(vec3 v, fp_t s);
        vec3 r;
        r.x = fp_mul(v.x, s);
        r.y = fp_mul(v.y, s);
        r.z = fp_mul(v.z, s);
        return r;
    endfunction

endpackage

// File: rtl/ray_march_ctrl_if.sv
// Result channel from the ray-march controller to the shading stage (valid/ready).
interface ray_march_ctrl_if #(
    parameter int unsigned STEP_W = 6
);

    import vector_pkg::*;

    logic              res_valid;
    logic              res_ready;
    logic              res_hit;
    fp_t               res_t;
    logic [STEP_W-1:0] res_steps;
    vec3               res_pos;

    modport master (
        output res_valid,
        output res_hit,
        output res_t,
        output res_steps,
        output res_pos,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_hit,
        input  res_t,
        input  res_steps,
        input  res_pos,
        output res_ready
    );

endinterface

// File: rtl/ray_step_update.sv
// One sphere-trace step: signed distance to the surface, hit/far decisions and the
// advanced position and saturated travelled distance.
module ray_step_update
    import common_defs::*;
    import vector_pkg::*;
#(
    parameter fp_t EPSILON  = EPSILON_DEFAULT,
    parameter fp_t MAX_DIST = MAX_DIST_DEFAULT
) (
    input  vec3  pos_i,
    input  vec3  dir_i,
    input  fp_t  t_i,
    input  fp_t  len_i,
    input  fp_t  radius_i,
    output vec3  pos_next_o,
    output fp_t  t_next_o,
    output logic hit_o,
    output logic far_o
);

    fp_t               d;
    logic signed [N:0] t_ext;
    logic signed [N:0] d_ext;
    logic signed [N:0] sum;

    always_comb begin
        d     = fp_sub(len_i, radius_i);
        t_ext = t_i;
        d_ext = d;
        sum   = t_ext + d_ext;
        // Sign bits disagree only on overflow; clamp to the representable extreme.
        if (sum[N] != sum[N-1]) begin
            t_next_o = sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            t_next_o = sum[N-1:0];
        end
        hit_o      = d < EPSILON;
        far_o      = t_next_o > MAX_DIST;
        pos_next_o = vec3_add(pos_i, vec3_scale(dir_i, d));
    end

endmodule

// File: rtl/ray_march_ctrl.sv
// Sequential sphere-trace controller: iterates pos-centre through an external length
// unit until the ray hits, leaves MAX_DIST or exhausts MAX_STEPS.
module ray_march_ctrl
    import common_defs::*;
    import vector_pkg::*;
#(
    parameter int unsigned MAX_STEPS = 32,
    parameter int unsigned STEP_W    = 6,
    parameter fp_t         EPSILON   = EPSILON_DEFAULT,
    parameter fp_t         MAX_DIST  = MAX_DIST_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  vec3                     origin_i,
    input  vec3                     dir_i,
    input  vec3                     centre_i,
    input  fp_t                     radius_i,
    output logic                    busy_o,
    output vec3                     len_vec_o,
    output logic                    len_valid_in_o,
    input  fp_t                     len_i,
    input  logic                    len_valid_out_i,
    ray_march_ctrl_if.master        res
);

    march_state_t      state_q, state_d;
    vec3               dir_q, dir_d;
    vec3               centre_q, centre_d;
    fp_t               radius_q, radius_d;
    vec3               pos_q, pos_d;
    fp_t               t_q, t_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    fp_t               len_q, len_d;
    vec3               len_vec_q, len_vec_d;
    logic              len_valid_q, len_valid_d;
    logic              hit_q, hit_d;

    vec3               upd_pos;
    fp_t               upd_t;
    logic              upd_hit;
    logic              upd_far;
    logic [STEP_W-1:0] steps_inc;

    assign steps_inc = steps_q + STEP_W'(1);

    ray_step_update #(
        .EPSILON  (EPSILON),
        .MAX_DIST (MAX_DIST)
    ) u_step (
        .pos_i      (pos_q),
        .dir_i      (dir_q),
        .t_i        (t_q),
        .len_i      (len_q),
        .radius_i   (radius_q),
        .pos_next_o (upd_pos),
        .t_next_o   (upd_t),
        .hit_o      (upd_hit),
        .far_o      (upd_far)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            dir_q       <= '0;
            centre_q    <= '0;
            radius_q    <= '0;
            pos_q       <= '0;
            t_q         <= '0;
            steps_q     <= '0;
            len_q       <= '0;
            len_vec_q   <= '0;
            len_valid_q <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            centre_q    <= centre_d;
            radius_q    <= radius_d;
            pos_q       <= pos_d;
            t_q         <= t_d;
            steps_q     <= steps_d;
            len_q       <= len_d;
            len_vec_q   <= len_vec_d;
            len_valid_q <= len_valid_d;
            hit_q       <= hit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        centre_d    = centre_q;
        radius_d    = radius_q;
        pos_d       = pos_q;
        t_d         = t_q;
        steps_d     = steps_q;
        len_d       = len_q;
        len_vec_d   = len_vec_q;
        len_valid_d = 1'b0;
        hit_d       = hit_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    dir_d    = dir_i;
                    centre_d = centre_i;
                    radius_d = radius_i;
                    pos_d    = origin_i;
                    t_d      = '0;
                    steps_d  = '0;
                    hit_d    = 1'b0;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                len_vec_d   = vec3_sub(pos_q, centre_q);
                len_valid_d = 1'b1;
                state_d     = StWait;
            end
            StWait: begin
                if (len_valid_out_i) begin
                    len_d   = len_i;
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                steps_d = steps_inc;
                if (upd_hit) begin
                    hit_d   = 1'b1;
                    state_d = StDone;
                end else if (upd_far) begin
                    // Past the far plane the position is left where the last step began.
                    hit_d   = 1'b0;
                    t_d     = upd_t;
                    state_d = StDone;
                end else begin
                    pos_d   = upd_pos;
                    t_d     = upd_t;
                    state_d = (steps_inc == STEP_W'(MAX_STEPS)) ? StDone : StIssue;
                end
            end
            StDone: begin
                if (res.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_o         = state_q != StIdle;
    assign len_vec_o      = len_vec_q;
    assign len_valid_in_o = len_valid_q;

    assign res.res_valid  = state_q == StDone;
    assign res.res_hit    = hit_q;
    assign res.res_t      = t_q;
    assign res.res_steps  = steps_q;
    assign res.res_pos    = pos_q;

endmodule
